ex_mem_stage: RTL

EX-to-MEM pipeline stage for the five-stage MIPS pipeline. It consumes the one-cycle-delayed rt/rd fields produced for the EX stage and resolves the destination register with RegDst. It registers the ALU result, store data and MEM/WB control bits into the EX/MEM latch and tracks one further stage of destination history. From that state it drives the ID-stage forwarding selects and the load-use stall request.

---
 rtl/ex_mem_stage.sv | 114 +++++++++++
 1 files changed

// File: rtl/ex_mem_stage.sv
// EX-to-MEM pipeline stage for a five-stage MIPS pipeline.
// Resolves the EX destination register, holds the EX/MEM latch plus one
// stage of MEM/WB destination history, and produces the ID-stage forwarding
// selects and the load-use stall request from that state.
module ex_mem_stage #(
   parameter int DW = 32,
   parameter int RW = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [RW-1:0] EX_Mux0,
   input  logic [RW-1:0] EX_Mux1,
   input  logic          regdst,
   input  logic          ewreg,
   input  logic          em2reg,
   input  logic          ewmem,
   input  logic [DW-1:0] ealu,
   input  logic [DW-1:0] eqb,
   input  logic          hold,
   input  logic          flush,
   input  logic [RW-1:0] id_rs,
   input  logic [RW-1:0] id_rt,
   output logic [RW-1:0] ern,
   output logic          mwreg,
   output logic          mm2reg,
   output logic          mwmem,
   output logic [RW-1:0] mrn,
   output logic [DW-1:0] malu,
   output logic [DW-1:0] mqb,
   output logic          wwreg,
   output logic [RW-1:0] wrn,
   output logic [1:0]    fwda,
   output logic [1:0]    fwdb,
   output logic          load_stall
);

   // Effective EX write: a write to $0 is dropped before it enters the pipe.
   logic ewv;

   // Forwarding select for one source register, first match wins.
   // A load in EX matching the source is skipped on purpose: that cycle is
   // covered by load_stall, so whatever lower-priority match remains is moot.
   function automatic logic [1:0] fwd_sel(
      input logic [RW-1:0] s,
      input logic          ex_wr,
      input logic          ex_ld,
      input logic [RW-1:0] ex_rn,
      input logic          m_wr,
      input logic          m_ld,
      input logic [RW-1:0] m_rn
   );
      logic [1:0] sel;
      sel = 2'b00;
      if (s == '0)
         sel = 2'b00;
      else if (ex_wr && !ex_ld && ex_rn == s)
         sel = 2'b01;
      else if (m_wr && !m_ld && m_rn == s)
         sel = 2'b10;
      else if (m_wr && m_ld && m_rn == s)
         sel = 2'b11;
      return sel;
   endfunction

   // Destination select (RegDst) and effective write enable, ungated.
   always_comb begin
      ern = regdst ? EX_Mux1 : EX_Mux0;
      ewv = ewreg && (ern != '0);
   end

   // ---- EX -> MEM / MEM -> WB boundary: priority rst > flush > hold > advance
   always_ff @(posedge clk) begin
      if (rst) begin
         mwreg  <= 1'b0;
         mm2reg <= 1'b0;
         mwmem  <= 1'b0;
         mrn    <= '0;
         malu   <= '0;
         mqb    <= '0;
         wwreg  <= 1'b0;
         wrn    <= '0;
      end else if (flush) begin
         // Bubble into MEM; the older instruction still retires into history.
         mwreg  <= 1'b0;
         mm2reg <= 1'b0;
         mwmem  <= 1'b0;
         mrn    <= '0;
         malu   <= '0;
         mqb    <= '0;
         wwreg  <= mwreg;
         wrn    <= mrn;
      end else if (!hold) begin
         mwreg  <= ewv;
         mm2reg <= em2reg && ewv;
         mwmem  <= ewmem;
         mrn    <= ern;
         malu   <= ealu;
         mqb    <= eqb;
         wwreg  <= mwreg;
         wrn    <= mrn;
      end
   end

   // Forwarding selects and load-use request, recomputed every cycle
   // (including during hold) from the current EX inputs and MEM state.
   always_comb begin
      fwda = fwd_sel(id_rs, ewv, em2reg, ern, mwreg, mm2reg, mrn);
      fwdb = fwd_sel(id_rt, ewv, em2reg, ern, mwreg, mm2reg, mrn);
      load_stall = ewv && em2reg &&
                   (((ern == id_rs) && (id_rs != '0)) ||
                    ((ern == id_rt) && (id_rt != '0)));
   end

endmodule
